// File: rtl/sysctrl_spi_regfile.sv
// System-control register file behind a mode-0 SPI slave. It holds the chip ID
// registers and the PLL control fields, and has a combinational parallel read port.
module sysctrl_spi_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_csb,
    input  logic        spi_sck,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [7:0]  reg_addr,
    output logic [7:0]  reg_rdata,
    output logic        pll_ena,
    output logic        pll_dco_ena,
    output logic        pll_bypass,
    output logic [23:0] pll_trim,
    output logic [2:0]  pll_sel,
    output logic [4:0]  pll_div,
    output logic [1:0]  dbg_state
);

    localparam logic [11:0] MFGR_ID  = 12'h456;
    localparam logic [7:0]  PROD_ID  = 8'h10;
    localparam logic [7:0]  MASK_REV = 8'h04;

    typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

    state_t      state;
    logic [1:0]  csb_sync, sck_sync, sdi_sync;
    logic        csb_prev, sck_prev;
    logic        csb_high, csb_fall, sck_rise, sck_fall, sdi_bit;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in, rx_byte, sdo_shift, addr, spi_rdata;
    logic        cmd_wr, cmd_rd, load_pending;

    logic [1:0]  r_pll_ctl;
    logic        r_bypass;
    logic [7:0]  r_trim_hi, r_trim_mid, r_trim_lo;
    logic [2:0]  r_sel;
    logic [4:0]  r_div;
    logic [7:0]  reg_map [12];

    // Synchronizers and edge history are deliberately not reset, so a csb held
    // low across reset is not seen as a new falling edge afterwards.
    always_ff @(posedge clock) begin
        csb_sync <= {csb_sync[0], spi_csb};
        sck_sync <= {sck_sync[0], spi_sck};
        sdi_sync <= {sdi_sync[0], spi_sdi};
        csb_prev <= csb_sync[1];
        sck_prev <= sck_sync[1];
    end

    assign csb_high = csb_sync[1];
    assign csb_fall = csb_prev & ~csb_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign sdi_bit  = sdi_sync[1];
    assign rx_byte  = {shift_in[6:0], sdi_bit};

    always_comb begin
        reg_map[0]  = 8'h00;
        reg_map[1]  = {4'h0, MFGR_ID[11:8]};
        reg_map[2]  = MFGR_ID[7:0];
        reg_map[3]  = PROD_ID;
        reg_map[4]  = {6'b0, r_pll_ctl};
        reg_map[5]  = {7'b0, r_bypass};
        reg_map[6]  = r_trim_hi;
        reg_map[7]  = r_trim_mid;
        reg_map[8]  = r_trim_lo;
        reg_map[9]  = {5'b0, r_sel};
        reg_map[10] = {3'b0, r_div};
        reg_map[11] = MASK_REV;
    end

    assign reg_rdata = (reg_addr < 8'd12) ? reg_map[reg_addr[3:0]] : 8'h00;
    assign spi_rdata = (addr < 8'd12) ? reg_map[addr[3:0]] : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift_in     <= 8'h00;
            sdo_shift    <= 8'h00;
            addr         <= 8'h00;
            cmd_wr       <= 1'b0;
            cmd_rd       <= 1'b0;
            load_pending <= 1'b0;
            spi_sdo      <= 1'b0;
            spi_sdo_oe   <= 1'b0;
            r_pll_ctl    <= 2'b10;
            r_bypass     <= 1'b1;
            r_trim_hi    <= 8'hFF;
            r_trim_mid   <= 8'hEF;
            r_trim_lo    <= 8'hFF;
            r_sel        <= 3'd3;
            r_div        <= 5'h12;
        end else if (csb_high) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            load_pending <= 1'b0;
            spi_sdo      <= 1'b0;
            spi_sdo_oe   <= 1'b0;
        end else if (state == IDLE) begin
            if (csb_fall) begin
                state   <= CMD;
                bit_cnt <= 3'd0;
            end
        end else begin
            if (sck_rise) begin
                shift_in <= rx_byte;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        CMD: begin
                            cmd_wr <= rx_byte[7];
                            cmd_rd <= rx_byte[6];
                            // A command with neither bit set parks in IDLE until csb rises.
                            state  <= (rx_byte[7:6] == 2'b00) ? IDLE : ADDR;
                        end
                        ADDR: begin
                            addr         <= rx_byte;
                            state        <= DATA;
                            load_pending <= 1'b1;
                        end
                        default: begin
                            if (cmd_wr) begin
                                case (addr)
                                    8'h04:   r_pll_ctl  <= rx_byte[1:0];
                                    8'h05:   r_bypass   <= rx_byte[0];
                                    8'h06:   r_trim_hi  <= rx_byte;
                                    8'h07:   r_trim_mid <= rx_byte;
                                    8'h08:   r_trim_lo  <= rx_byte;
                                    8'h09:   r_sel      <= rx_byte[2:0];
                                    8'h0A:   r_div      <= rx_byte[4:0];
                                    default: ;
                                endcase
                            end
                            addr         <= addr + 8'd1;
                            load_pending <= 1'b1;
                        end
                    endcase
                end
            end
            // The first fall of a data slot loads the byte; later falls shift it out.
            if (sck_fall && state == DATA) begin
                if (load_pending) begin
                    load_pending <= 1'b0;
                    if (cmd_rd) begin
                        spi_sdo    <= spi_rdata[7];
                        sdo_shift  <= {spi_rdata[6:0], 1'b0};
                        spi_sdo_oe <= 1'b1;
                    end
                end else begin
                    spi_sdo   <= sdo_shift[7];
                    sdo_shift <= {sdo_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign pll_ena     = r_pll_ctl[0];
    assign pll_dco_ena = r_pll_ctl[1];
    assign pll_bypass  = r_bypass;
    assign pll_trim    = {r_trim_hi, r_trim_mid, r_trim_lo};
    assign pll_sel     = r_sel;
    assign pll_div     = r_div;
    assign dbg_state   = state;

endmodule

// File: tb/tb_sysctrl_spi_regfile.sv
// Bench for sysctrl_spi_regfile: an SPI master driver with a register-map model;
// received bytes go through a queue to a monitor that compares them with expectations.
module tb_sysctrl_spi_regfile;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_csb = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo, spi_sdo_oe;
    logic [7:0]  reg_addr = 8'h00;
    logic [7:0]  reg_rdata;
    logic        pll_ena, pll_dco_ena, pll_bypass;
    logic [23:0] pll_trim;
    logic [2:0]  pll_sel;
    logic [4:0]  pll_div;
    logic [1:0]  dbg_state;

    sysctrl_spi_regfile dut (
        .clock(clock), .reset(reset),
        .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .reg_addr(reg_addr), .reg_rdata(reg_rdata),
        .pll_ena(pll_ena), .pll_dco_ena(pll_dco_ena), .pll_bypass(pll_bypass),
        .pll_trim(pll_trim), .pll_sel(pll_sel), .pll_div(pll_div),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int byte_idx = 0;

    // exp_q entries are {mask[9:0], value[9:0]}; got_q entries are {oe_any, oe_all, sdo_byte}
    logic [19:0] exp_q[$];
    logic [9:0]  got_q[$];

    logic [7:0] m_reg [256];
    logic [7:0] data_buf [16];

    function automatic logic [7:0] wmask(input logic [7:0] a);
        case (a)
            8'h04: return 8'h03;
            8'h05: return 8'h01;
            8'h06, 8'h07, 8'h08: return 8'hFF;
            8'h09: return 8'h07;
            8'h0A: return 8'h1F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
        m_reg[1] = 8'h04; m_reg[2] = 8'h56; m_reg[3] = 8'h10;
        m_reg[4] = 8'h02; m_reg[5] = 8'h01; m_reg[6] = 8'hFF;
        m_reg[7] = 8'hEF; m_reg[8] = 8'hFF; m_reg[9] = 8'h03;
        m_reg[10] = 8'h12; m_reg[11] = 8'h04;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        m_reg[a] = (m_reg[a] & ~wmask(a)) | (d & wmask(a));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_fields(input string tag);
        logic [7:0] r4, r5;
        r4 = m_reg[4];
        r5 = m_reg[5];
        chk({tag, " pll_ena"}, {31'b0, pll_ena}, {31'b0, r4[0]});
        chk({tag, " pll_dco_ena"}, {31'b0, pll_dco_ena}, {31'b0, r4[1]});
        chk({tag, " pll_bypass"}, {31'b0, pll_bypass}, {31'b0, r5[0]});
        chk({tag, " pll_trim"}, {8'b0, pll_trim}, {8'b0, m_reg[6], m_reg[7], m_reg[8]});
        chk({tag, " pll_sel"}, {29'b0, pll_sel}, {24'b0, m_reg[9]});
        chk({tag, " pll_div"}, {27'b0, pll_div}, {24'b0, m_reg[10]});
    endtask

    task automatic check_rdata(input logic [7:0] a);
        reg_addr = a;
        @(negedge clock);
        chk($sformatf("reg_rdata[%02h]", a), {24'b0, reg_rdata}, {24'b0, m_reg[a]});
    endtask

    // Shifts the top n bits of tx; samples sdo and oe just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx, output logic oe_any, output logic oe_all);
        rx = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            spi_sdi = tx[i];
            repeat (HALF) @(negedge clock);
            rx[i] = spi_sdo;
            oe_any = oe_any | spi_sdo_oe;
            oe_all = oe_all & spi_sdo_oe;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] start, input int n);
        logic [7:0] rx, a;
        logic any, all;
        exp_q.push_back({10'h300, 10'h000});
        exp_q.push_back({10'h300, 10'h000});
        for (int k = 0; k < n; k++) begin
            a = start + 8'(k);
            if (cmd[6]) exp_q.push_back({10'h3FF, 2'b11, m_reg[a]});
            else        exp_q.push_back({10'h300, 10'h000});
            if (cmd[7]) model_write(a, data_buf[k]);
        end
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clock);
        spi_bits(cmd, 8, rx, any, all);
        got_q.push_back({any, all, rx});
        spi_bits(start, 8, rx, any, all);
        got_q.push_back({any, all, rx});
        for (int k = 0; k < n; k++) begin
            spi_bits(data_buf[k], 8, rx, any, all);
            got_q.push_back({any, all, rx});
        end
        repeat (HALF) @(negedge clock);
        spi_csb = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    initial begin : monitor
        logic [9:0]  g;
        logic [19:0] e;
        forever begin
            @(negedge clock);
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spi_byte%0d: got 0x%03h with no expected entry", byte_idx, g);
                end else begin
                    e = exp_q.pop_front();
                    if ((g & e[19:10]) !== (e[9:0] & e[19:10])) begin
                        errors++;
                        $display("FAIL spi_byte%0d: got {oe_any,oe_all,sdo}=0x%03h expected 0x%03h mask 0x%03h",
                                 byte_idx, g, e[9:0], e[19:10]);
                    end
                end
                byte_idx++;
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rx, cmd, a;
        logic any, all;
        int n;

        model_reset();
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset spi_sdo", {31'b0, spi_sdo}, 32'd0);
        chk("reset spi_sdo_oe", {31'b0, spi_sdo_oe}, 32'd0);
        chk("reset pll_trim", {8'b0, pll_trim}, 32'h00FFEFFF);
        check_fields("reset");
        check_rdata(8'h02);
        check_rdata(8'h0B);
        check_rdata(8'h0C);

        // Identification and default readout
        run_txn(8'h40, 8'h01, 11);

        data_buf[0] = 8'h07;
        run_txn(8'h80, 8'h0A, 1);
        check_fields("wr_div");
        chk("pll_div=7", {27'b0, pll_div}, 32'd7);
        run_txn(8'h40, 8'h0A, 1);
        check_rdata(8'h0A);

        data_buf[0] = 8'hAA;
        run_txn(8'h80, 8'h01, 1);
        run_txn(8'h40, 8'h01, 1);
        check_fields("wr_ro");
        data_buf[0] = 8'hFF;
        run_txn(8'h80, 8'h09, 1);
        run_txn(8'h40, 8'h09, 1);
        chk("pll_sel=7", {29'b0, pll_sel}, 32'd7);

        data_buf[0] = 8'h00;
        run_txn(8'hC0, 8'h05, 1);
        chk("pll_bypass=0", {31'b0, pll_bypass}, 32'd0);

        // Write aborted after half a data byte
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clock);
        spi_bits(8'h80, 8, rx, any, all);
        spi_bits(8'h06, 8, rx, any, all);
        spi_bits(8'h12, 4, rx, any, all);
        spi_csb = 1'b1;
        repeat (2 * HALF) @(negedge clock);
        chk("abort pll_trim", {8'b0, pll_trim}, 32'h00FFEFFF);
        check_fields("abort");

        run_txn(8'h40, 8'hFF, 2);

        // Reset during a read data slot, then SPI activity must be ignored
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clock);
        spi_bits(8'h40, 8, rx, any, all);
        spi_bits(8'h05, 8, rx, any, all);
        spi_bits(8'h00, 3, rx, any, all);
        chk("pre-reset oe", {31'b0, spi_sdo_oe}, 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk("midreset spi_sdo_oe", {31'b0, spi_sdo_oe}, 32'd0);
        chk("midreset spi_sdo", {31'b0, spi_sdo}, 32'd0);
        check_fields("midreset");
        spi_bits(8'h00, 5, rx, any, all);
        spi_bits(8'h00, 8, rx, any, all);
        chk("post-reset oe_any", {31'b0, any}, 32'd0);
        spi_csb = 1'b1;
        repeat (2 * HALF) @(negedge clock);

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: cmd = 8'h80;
                1: cmd = 8'h40;
                2: cmd = 8'hC0;
                default: cmd = 8'h00;
            endcase
            a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) data_buf[k] = 8'($urandom);
            run_txn(cmd, a, n);
            check_fields($sformatf("rand%0d", t));
            check_rdata(8'($urandom_range(0, 15)));
        end

        repeat (5) @(negedge clock);
        chk("exp_q drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
